// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with byte write enables, selectable write mode/read latency and a post-reset clear sweep.
// Optional build macro RAM_SP_BE_PARITY_EN adds per-byte even parity storage and a perr output.
module ram_sp_be #(
   parameter int    DW             = 16,
   parameter int    DEPTH          = 1024,
   parameter int    READ_LATENCY   = 1,
   parameter string WRITE_MODE     = "WRITE_FIRST",
   parameter bit    CLEAR_ON_RESET = 1'b1,
   localparam int   AW             = $clog2(DEPTH),
   localparam int   NB             = DW / 8
) (
   input  logic          clka,
   input  logic          rsta,
   input  logic          ena,
   input  logic [NB-1:0] wea,
   input  logic [AW-1:0] addra,
   input  logic [DW-1:0] dina,
   output logic [DW-1:0] douta,
   output logic          dout_vld,
`ifdef RAM_SP_BE_PARITY_EN
   output logic [NB-1:0] perr,
`endif
   output logic          busy
);

   localparam bit            WF        = (WRITE_MODE == "WRITE_FIRST");
   localparam bit            NC        = (WRITE_MODE == "NO_CHANGE");
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
`ifdef RAM_SP_BE_PARITY_EN
   localparam int            PLW       = DW + NB;
`else
   localparam int            PLW       = DW;
`endif

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

   state_e         state_q, state_d;
   logic [AW-1:0]  ptr_q, ptr_d;
   logic [DW-1:0]  mem_q [DEPTH];
   logic           busy_s, acc_s, in_range_s, res_vld_s, out_vld_s;
   logic [DW-1:0]  rd_word_s, merged_s, res_data_s;
   logic [PLW-1:0] res_pl_s, out_pl_s;
   logic [DW-1:0]  douta_q;
   logic           dout_vld_q;

   // clear sequencer state register
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // clear sequencer next state: walk every word once, then idle
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_CLEAR: begin
            if (ptr_q == LAST_ADDR) begin
               state_d = S_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d   = ptr_q + AW'(1);
            end
         end
         S_IDLE: begin
            state_d = S_IDLE;
            ptr_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   assign busy_s = (state_q == S_CLEAR);

   // access decode, byte merge and read-result selection
   always_comb begin
      acc_s      = ena & ~busy_s & ~rsta;
      in_range_s = (32'(addra) < 32'(DEPTH));
      rd_word_s  = mem_q[addra];
      merged_s   = rd_word_s;
      for (int i = 0; i < NB; i++) begin
         merged_s[8*i +: 8] = wea[i] ? dina[8*i +: 8] : rd_word_s[8*i +: 8];
      end
      res_data_s = in_range_s ? (WF ? merged_s : rd_word_s) : '0;
      // a write under NO_CHANGE produces no result at all
      res_vld_s  = acc_s & ~(NC & (|wea));
   end

`ifdef RAM_SP_BE_PARITY_EN
   logic [NB-1:0] par_q [DEPTH];
   logic [NB-1:0] din_par_s, rd_par_s, merged_par_s, res_perr_s;

   function automatic logic [NB-1:0] lane_parity(input logic [DW-1:0] word);
      logic [NB-1:0] p;
      p = '0;
      for (int i = 0; i < NB; i++) begin
         p[i] = ^word[8*i +: 8];
      end
      return p;
   endfunction

   // parity merge and per-lane mismatch detection
   always_comb begin
      din_par_s    = lane_parity(dina);
      rd_par_s     = par_q[addra];
      merged_par_s = (wea & din_par_s) | (~wea & rd_par_s);
      if (!in_range_s) begin
         res_perr_s = '0;
      end else if (WF) begin
         res_perr_s = lane_parity(merged_s) ^ merged_par_s;
      end else begin
         res_perr_s = lane_parity(rd_word_s) ^ rd_par_s;
      end
      res_pl_s = {res_perr_s, res_data_s};
   end
`else
   assign res_pl_s = res_data_s;
`endif

   // array write port; out-of-range writes are discarded, reset leaves contents alone
   always_ff @(posedge clka) begin
      if (busy_s && !rsta) begin
         mem_q[ptr_q] <= '0;
`ifdef RAM_SP_BE_PARITY_EN
         par_q[ptr_q] <= '0;
`endif
      end else if (acc_s && in_range_s) begin
         mem_q[addra] <= merged_s;
`ifdef RAM_SP_BE_PARITY_EN
         par_q[addra] <= merged_par_s;
`endif
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic           s1_vld_q;
         logic [PLW-1:0] s1_pl_q;

         // extra read pipeline stage
         always_ff @(posedge clka) begin
            if (rsta) begin
               s1_vld_q <= 1'b0;
               s1_pl_q  <= '0;
            end else begin
               s1_vld_q <= res_vld_s;
               s1_pl_q  <= res_pl_s;
            end
         end
         assign out_vld_s = s1_vld_q;
         assign out_pl_s  = s1_pl_q;
      end else begin : g_lat1
         assign out_vld_s = res_vld_s;
         assign out_pl_s  = res_pl_s;
      end
   endgenerate

   // output register: douta holds between results
   always_ff @(posedge clka) begin
      if (rsta) begin
         douta_q    <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         dout_vld_q <= out_vld_s;
         if (out_vld_s) begin
            douta_q <= out_pl_s[DW-1:0];
         end
      end
   end

`ifdef RAM_SP_BE_PARITY_EN
   logic [NB-1:0] perr_q;

   // parity error flags, forced low whenever no result is presented
   always_ff @(posedge clka) begin
      if (rsta) begin
         perr_q <= '0;
      end else begin
         perr_q <= out_vld_s ? out_pl_s[PLW-1:DW] : '0;
      end
   end
   assign perr = perr_q;
`endif

   assign douta    = douta_q;
   assign dout_vld = dout_vld_q;
   assign busy     = busy_s;

endmodule

// File: tb/tb_ram_sp_be.sv
// Self-checking bench: three ram_sp_be configurations driven with shared directed and random stimulus,
// compared every cycle against a word-array reference model.
module tb_ram_sp_be;

   localparam int NK = 3;

   logic        clk = 1'b0;
   logic        rsta, ena;
   logic [1:0]  wea;
   logic [9:0]  addra;
   logic [15:0] dina;

   logic [15:0] obs_d [NK];
   logic        obs_v [NK];
   logic        obs_b [NK];
`ifdef RAM_SP_BE_PARITY_EN
   logic [1:0]  obs_p [NK];
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [15:0] mem_m  [NK][1024];
   int          clr_left [NK];
   logic [15:0] exp_d  [NK];
   logic        exp_v  [NK];
   logic        pend_v [NK];
   logic [15:0] pend_d [NK];

   always #5 clk = ~clk;

   ram_sp_be #(.DW(16), .DEPTH(1024), .READ_LATENCY(1), .WRITE_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1'b1)) u_k0 (
      .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(obs_d[0]), .dout_vld(obs_v[0]),
`ifdef RAM_SP_BE_PARITY_EN
      .perr(obs_p[0]),
`endif
      .busy(obs_b[0]));

   ram_sp_be #(.DW(16), .DEPTH(1000), .READ_LATENCY(2), .WRITE_MODE("READ_FIRST"), .CLEAR_ON_RESET(1'b1)) u_k1 (
      .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(obs_d[1]), .dout_vld(obs_v[1]),
`ifdef RAM_SP_BE_PARITY_EN
      .perr(obs_p[1]),
`endif
      .busy(obs_b[1]));

   ram_sp_be #(.DW(16), .DEPTH(1024), .READ_LATENCY(2), .WRITE_MODE("NO_CHANGE"), .CLEAR_ON_RESET(1'b1)) u_k2 (
      .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(obs_d[2]), .dout_vld(obs_v[2]),
`ifdef RAM_SP_BE_PARITY_EN
      .perr(obs_p[2]),
`endif
      .busy(obs_b[2]));

   function automatic int dep(input int k);
      case (k)
         1:       return 1000;
         default: return 1024;
      endcase
   endfunction

   function automatic int lat(input int k);
      case (k)
         0:       return 1;
         default: return 2;
      endcase
   endfunction

   // 0 = write-first, 1 = read-first, 2 = no-change
   function automatic int wmode(input int k);
      case (k)
         1:       return 1;
         2:       return 2;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_edge();
      logic        acc, inr, produce;
      logic [15:0] old_w, new_w, data;
      for (int k = 0; k < NK; k++) begin
         if (rsta) begin
            clr_left[k] = dep(k);
            exp_v[k]    = 1'b0;
            exp_d[k]    = 16'h0000;
            pend_v[k]   = 1'b0;
         end else begin
            acc     = ena && (clr_left[k] == 0);
            produce = 1'b0;
            data    = 16'h0000;
            if (clr_left[k] > 0) begin
               mem_m[k][dep(k) - clr_left[k]] = 16'h0000;
               clr_left[k]--;
            end
            if (acc) begin
               inr   = (int'(addra) < dep(k));
               old_w = inr ? mem_m[k][addra] : 16'h0000;
               new_w = old_w;
               if (wea[0]) new_w[7:0]  = dina[7:0];
               if (wea[1]) new_w[15:8] = dina[15:8];
               if (inr) mem_m[k][addra] = new_w;
               else new_w = 16'h0000;
               case (wmode(k))
                  0:       begin produce = 1'b1;           data = new_w; end
                  1:       begin produce = 1'b1;           data = old_w; end
                  default: begin produce = (wea == 2'b00); data = old_w; end
               endcase
            end
            if (lat(k) == 1) begin
               exp_v[k] = produce;
               if (produce) exp_d[k] = data;
            end else begin
               exp_v[k] = pend_v[k];
               if (pend_v[k]) exp_d[k] = pend_d[k];
               pend_v[k] = produce;
               pend_d[k] = data;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NK; k++) begin
         chk($sformatf("k%0d_busy", k), 16'(obs_b[k]), 16'(clr_left[k] > 0));
         chk($sformatf("k%0d_vld", k),  16'(obs_v[k]), 16'(exp_v[k]));
         chk($sformatf("k%0d_dout", k), obs_d[k], exp_d[k]);
`ifdef RAM_SP_BE_PARITY_EN
         chk($sformatf("k%0d_perr", k), 16'(obs_p[k]), 16'h0000);
`endif
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [1:0] w,
                       input logic [9:0] a, input logic [15:0] d);
      rsta  = r;
      ena   = e;
      wea   = w;
      addra = a;
      dina  = d;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000);
   endtask

   function automatic logic [9:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 10'($urandom_range(990, 1023));
      return 10'($urandom_range(0, 15));
   endfunction

   initial begin
      int  cnt;
      logic saw_vld;
      for (int k = 0; k < NK; k++) begin
         for (int a = 0; a < 1024; a++) mem_m[k][a] = 16'h0000;
         clr_left[k] = 0; exp_v[k] = 1'b0; exp_d[k] = 16'h0000;
         pend_v[k] = 1'b0; pend_d[k] = 16'h0000;
      end
      rsta = 1'b1; ena = 1'b0; wea = 2'b00; addra = 10'd0; dina = 16'h0000;

      // reset, then abort the sweep at cycle 500 with ena held high
      step(1'b1, 1'b0, 2'b00, 10'd0, 16'h0000);
      step(1'b1, 1'b1, 2'b11, 10'd0, 16'h0000);
      chk("reset_busy", 16'(obs_b[0]), 16'h0001);
      chk("reset_vld",  16'(obs_v[0]), 16'h0000);
      chk("reset_dout", obs_d[0], 16'h0000);
      for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 2'($urandom), rand_addr(), 16'($urandom));
      step(1'b1, 1'b1, 2'b11, 10'd0, 16'h0000);
      cnt     = obs_b[0] ? 1 : 0;
      saw_vld = 1'b0;
      for (int i = 0; i < 1100 && obs_b[0]; i++) begin
         step(1'b0, 1'b1, 2'($urandom), rand_addr(), 16'($urandom));
         if (obs_b[0]) cnt++;
         if (obs_v[0]) saw_vld = 1'b1;
      end
      chk("sweep_len", 16'(cnt), 16'd1024);
      chk("sweep_no_vld", 16'(saw_vld), 16'h0000);

      // last word cleared
      step(1'b0, 1'b1, 2'b00, 10'h3FF, 16'h0000);
      chk("clr_last", obs_d[0], 16'h0000);

      // byte merge, write-first, latency 1
      step(1'b0, 1'b1, 2'b11, 10'd5, 16'hA55A);
      chk("wf_full", obs_d[0], 16'hA55A);
      step(1'b0, 1'b1, 2'b01, 10'd5, 16'h00FF);
      step(1'b0, 1'b1, 2'b00, 10'd5, 16'h0000);
      chk("merge_rd", obs_d[0], 16'hA5FF);
      chk("merge_vld", 16'(obs_v[0]), 16'h0001);

      // read-first, latency 2
      step(1'b0, 1'b1, 2'b11, 10'd7, 16'h1234);
      step(1'b0, 1'b1, 2'b11, 10'd7, 16'hBEEF);
      idle();
      chk("rf_old", obs_d[1], 16'h1234);
      chk("rf_vld", 16'(obs_v[1]), 16'h0001);
      step(1'b0, 1'b1, 2'b00, 10'd7, 16'h0000);
      idle();
      chk("rf_new", obs_d[1], 16'hBEEF);

      // no-change, latency 2
      step(1'b0, 1'b1, 2'b11, 10'd3, 16'h1111);
      step(1'b0, 1'b1, 2'b00, 10'd3, 16'h0000);
      idle();
      chk("nc_rd1", obs_d[2], 16'h1111);
      step(1'b0, 1'b1, 2'b11, 10'd3, 16'h2222);
      idle();
      chk("nc_hold", obs_d[2], 16'h1111);
      chk("nc_novld", 16'(obs_v[2]), 16'h0000);
      step(1'b0, 1'b1, 2'b00, 10'd3, 16'h0000);
      idle();
      chk("nc_rd2", obs_d[2], 16'h2222);

      // out-of-range on the 1000-word instance
      step(1'b0, 1'b1, 2'b11, 10'd999, 16'h5A5A);
      step(1'b0, 1'b1, 2'b11, 10'd1010, 16'hFFFF);
      step(1'b0, 1'b1, 2'b00, 10'd1010, 16'h0000);
      idle();
      chk("oor_rd", obs_d[1], 16'h0000);
      chk("oor_vld", 16'(obs_v[1]), 16'h0001);
      step(1'b0, 1'b1, 2'b00, 10'd999, 16'h0000);
      idle();
      chk("oor_999", obs_d[1], 16'h5A5A);

      // random traffic with occasional resets
      for (int i = 0; i < 2500; i++) begin
         step(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom), rand_addr(), 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
